// File: rtl/lsu_axi.sv
// lsu_axi: load/store unit bridging a single-issue core port to an AXI-Lite master.
// Define YSYX_23060251_LSU_MISALIGN_EN to fault misaligned loads/stores without issuing AXI beats.
module lsu_axi #(
  parameter int XLEN   = 32,
  parameter int AXI_DW = 64,
  parameter int AXI_AW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                M_valid_i,
  output logic                m_ready_o,
  input  logic                renMem_i,
  input  logic                wenMem_i,
  input  logic                wenReg_i,
  input  logic                wenCsr_i,
  input  logic                is_load_signed_i,
  input  logic [1:0]          size_i,
  input  logic [AXI_AW-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                wb_en_o,
  output logic                err_o,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [AXI_AW-1:0]   ar_addr,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [AXI_DW-1:0]   r_data,
  input  logic [1:0]          r_resp,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [AXI_AW-1:0]   aw_addr,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [AXI_DW-1:0]   w_data,
  output logic [AXI_DW/8-1:0] w_strb,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);
  localparam int SW = AXI_DW / 8;
  localparam int OW = $clog2(SW);
  localparam logic [7:0] XL = 8'(XLEN);
  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, WB} state_t;
  state_t state;
  logic [AXI_DW-1:0] ld_q, ld_sh;
  logic err_q, aw_done, w_done, mis, mem;
  logic [OW-1:0] off;
  logic [15:0] smask;
  logic [7:0] nbits, sa;
  logic [XLEN-1:0] lo;
  logic signed [XLEN-1:0] sx;
  logic unused_resp;
  assign off = addr_i[OW-1:0];
  assign mem = renMem_i | wenMem_i;
  assign unused_resp = ^{r_resp[0], b_resp[0]};
`ifdef YSYX_23060251_LSU_MISALIGN_EN
  assign mis = |(addr_i[2:0] & ((3'd1 << size_i) - 3'd1));
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      ld_q    <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (M_valid_i) begin
          err_q   <= mis & mem;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          state   <= (mem & mis) ? WB : renMem_i ? AR : wenMem_i ? AWW :
                     (wenReg_i | wenCsr_i) ? WB : IDLE;
        end
        AR: if (ar_ready) state <= R;
        R: if (r_valid) begin
          ld_q  <= r_data;
          err_q <= r_resp[1];
          state <= WB;
        end
        AWW: begin
          aw_done <= aw_done | aw_ready;
          w_done  <= w_done | w_ready;
          if ((aw_done | aw_ready) & (w_done | w_ready)) state <= B;
        end
        B: if (b_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign ar_valid  = state == AR;
  assign r_ready   = state == R;
  assign aw_valid  = (state == AWW) & ~aw_done;
  assign w_valid   = (state == AWW) & ~w_done;
  assign b_ready   = state == B;
  assign m_ready_o = (state == WB) | ((state == B) & b_valid);
  assign err_o     = ((state == WB) & err_q) | ((state == B) & b_valid & b_resp[1]);
  assign wb_en_o   = (state == WB) & ~err_q;
  assign ar_addr   = addr_i;
  assign aw_addr   = addr_i;
  // Replicating wdata lets unshifted upper lanes carry a copy of the low bytes.
  assign w_data    = {(AXI_DW/XLEN){wdata_i}} << {off, 3'b0};
  assign smask     = (16'd1 << (5'd1 << size_i)) - 16'd1;
  assign w_strb    = SW'(smask << off);
  // Left-justify the selected bytes then shift back, so the arithmetic shift sign-extends.
  always_comb begin
    ld_sh   = ld_q >> {off, 3'b0};
    nbits   = 8'd8 << size_i;
    sa      = (nbits >= XL) ? 8'd0 : XL - nbits;
    lo      = ld_sh[XLEN-1:0] << sa;
    sx      = $signed(lo) >>> sa;
    rdata_o = is_load_signed_i ? sx : lo >> sa;
  end
endmodule
